// File: rtl/riscvio2i_rob_ctrl_pkg.sv
// Shared ROB definitions: geometry, per-slot entry layout, ROB bypass select code.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscvio2i_rob_ctrl_pkg;

    localparam int ROB_ENTRIES = 16;
    localparam int ROB_SLOT_W  = $clog2(ROB_ENTRIES);
    localparam int REG_AW      = 5;

    // Issue-stage operand mux select that picks the ROB bypass path.
    localparam logic [2:0] BYP_SEL_ROB = 3'd5;

    typedef struct packed {
        logic              valid;
        logic              filled;
        logic              wen;
        logic [REG_AW-1:0] waddr;
    } rob_entry_t;

    // True when this entry is an in-flight writer of raddr (x0 never matches).
    function automatic logic rob_writes_reg(input rob_entry_t ent, input logic [REG_AW-1:0] raddr);
        return (raddr != '0) && ent.valid && ent.wen && (ent.waddr == raddr);
    endfunction

endpackage

// File: rtl/riscvio2i_rob_ctrl_if.sv
// ROB control bundle between issue/writeback/commit datapath (master) and ROB control (slave).
// Latency: wires only.
// Backpressure: alloc_val/alloc_rdy handshake; fill and commit are unconditional strobes.
interface riscvio2i_rob_ctrl_if
    import riscvio2i_rob_ctrl_pkg::*;
#(
    parameter int SLOT_W = ROB_SLOT_W
);
    // allocation at issue
    logic              alloc_val;
    logic              alloc_rdy;
    logic              alloc_wen;
    logic [REG_AW-1:0] alloc_waddr;
    logic [SLOT_W-1:0] alloc_slot;
    // writeback fill
    logic              rob_fill_wen_Whl;
    logic [SLOT_W-1:0] rob_fill_slot_Whl;
    // in-order commit
    logic              commit_val;
    logic              rob_commit_wen_Chl;
    logic [SLOT_W-1:0] rob_commit_slot_Chl;
    logic [REG_AW-1:0] rob_commit_waddr_Chl;
    // operand lookup
    logic [REG_AW-1:0] op0_raddr;
    logic [REG_AW-1:0] op1_raddr;
    logic              op0_rob_hit;
    logic              op1_rob_hit;
    logic              op0_rob_rdy;
    logic              op1_rob_rdy;
    logic [SLOT_W-1:0] op0_rob_slot;
    logic [SLOT_W-1:0] op1_rob_slot;
    // status
    logic              rob_empty;
    logic              rob_full;

    modport master (
        output alloc_val, alloc_wen, alloc_waddr, rob_fill_wen_Whl, rob_fill_slot_Whl,
               op0_raddr, op1_raddr,
        input  alloc_rdy, alloc_slot, commit_val, rob_commit_wen_Chl, rob_commit_slot_Chl,
               rob_commit_waddr_Chl, op0_rob_hit, op1_rob_hit, op0_rob_rdy, op1_rob_rdy,
               op0_rob_slot, op1_rob_slot, rob_empty, rob_full
    );

    modport slave (
        input  alloc_val, alloc_wen, alloc_waddr, rob_fill_wen_Whl, rob_fill_slot_Whl,
               op0_raddr, op1_raddr,
        output alloc_rdy, alloc_slot, commit_val, rob_commit_wen_Chl, rob_commit_slot_Chl,
               rob_commit_waddr_Chl, op0_rob_hit, op1_rob_hit, op0_rob_rdy, op1_rob_rdy,
               op0_rob_slot, op1_rob_slot, rob_empty, rob_full
    );

endinterface

// File: rtl/riscvio2i_rob_lookup.sv
// Youngest in-flight writer search for one source operand across all ROB slots.
// Latency: combinational.
// Backpressure: none; caller stalls issue on hit && !rdy.
// Ports: i_ent (all slots), i_head (oldest slot), i_raddr -> o_hit, o_rdy, o_slot.
module riscvio2i_rob_lookup
    import riscvio2i_rob_ctrl_pkg::*;
#(
    parameter int ENTRIES = ROB_ENTRIES,
    parameter int SLOT_W  = ROB_SLOT_W
) (
    input  rob_entry_t [ENTRIES-1:0] i_ent,
    input  logic [SLOT_W-1:0]        i_head,
    input  logic [REG_AW-1:0]        i_raddr,
    output logic                     o_hit,
    output logic                     o_rdy,
    output logic [SLOT_W-1:0]        o_slot
);

    // Walk oldest to youngest starting at head; every later match overrides, so the
    // youngest writer wins. Only occupied slots are valid, so the tail need not be known.
    always_comb begin
        o_hit  = 1'b0;
        o_rdy  = 1'b0;
        o_slot = '0;
        for (int k = 0; k < ENTRIES; k++) begin
            logic [SLOT_W-1:0] w_idx;
            w_idx = i_head + SLOT_W'(k);
            if (rob_writes_reg(i_ent[w_idx], i_raddr)) begin
                o_hit  = 1'b1;
                o_rdy  = i_ent[w_idx].filled;
                o_slot = w_idx;
            end
        end
    end

endmodule

// File: rtl/riscvio2i_rob_ctrl.sv
// Reorder-buffer control: allocate at issue, mark filled at writeback, commit in order, bypass lookup.
// Latency: alloc/fill take effect at the edge; commit is combinational from registered state (fill N -> commit N+1).
// Backpressure: alloc_rdy = !rob_full; a same-cycle commit does not free a slot for that cycle's allocation.
// Ports: clk, reset (sync, active-high), rob (slave side of riscvio2i_rob_ctrl_if).
module riscvio2i_rob_ctrl
    import riscvio2i_rob_ctrl_pkg::*;
#(
    parameter int ENTRIES = ROB_ENTRIES,
    parameter int SLOT_W  = ROB_SLOT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    riscvio2i_rob_ctrl_if.slave   rob
);

    rob_entry_t [ENTRIES-1:0] r_ent;
    logic [SLOT_W:0]          r_head;   // extra MSB is the wrap bit
    logic [SLOT_W:0]          r_tail;

    logic [SLOT_W:0]          w_count;
    logic                     w_full;
    logic                     w_alloc_fire;
    logic                     w_commit;
    logic [SLOT_W-1:0]        w_head_slot;
    logic [SLOT_W-1:0]        w_tail_slot;
    rob_entry_t               w_head_ent;

    assign w_count      = r_tail - r_head;
    assign w_full       = (w_count == (SLOT_W+1)'(ENTRIES));
    assign w_head_slot  = r_head[SLOT_W-1:0];
    assign w_tail_slot  = r_tail[SLOT_W-1:0];
    assign w_head_ent   = r_ent[w_head_slot];
    assign w_alloc_fire = rob.alloc_val && !w_full;
    assign w_commit     = w_head_ent.valid && w_head_ent.filled;

    assign rob.alloc_rdy            = !w_full;
    assign rob.alloc_slot           = w_tail_slot;
    assign rob.rob_empty            = (w_count == '0);
    assign rob.rob_full             = w_full;
    assign rob.commit_val           = w_commit;
    assign rob.rob_commit_wen_Chl   = w_commit && w_head_ent.wen && (w_head_ent.waddr != '0);
    assign rob.rob_commit_slot_Chl  = w_head_slot;
    assign rob.rob_commit_waddr_Chl = w_head_ent.waddr;

    // Fill, commit and alloc always touch distinct slots when legal; commit is written
    // after fill so a retiring slot is cleared even if writeback strobes it again.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ent  <= '0;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (rob.rob_fill_wen_Whl && r_ent[rob.rob_fill_slot_Whl].valid) begin
                r_ent[rob.rob_fill_slot_Whl].filled <= 1'b1;
            end
            if (w_commit) begin
                r_ent[w_head_slot].valid  <= 1'b0;
                r_ent[w_head_slot].filled <= 1'b0;
                r_head                    <= r_head + 1'b1;
            end
            if (w_alloc_fire) begin
                r_ent[w_tail_slot] <= '{valid: 1'b1, filled: 1'b0,
                                        wen: rob.alloc_wen, waddr: rob.alloc_waddr};
                r_tail             <= r_tail + 1'b1;
            end
        end
    end

    riscvio2i_rob_lookup #(.ENTRIES(ENTRIES), .SLOT_W(SLOT_W)) u_lookup_op0 (
        .i_ent   (r_ent),
        .i_head  (w_head_slot),
        .i_raddr (rob.op0_raddr),
        .o_hit   (rob.op0_rob_hit),
        .o_rdy   (rob.op0_rob_rdy),
        .o_slot  (rob.op0_rob_slot)
    );

    riscvio2i_rob_lookup #(.ENTRIES(ENTRIES), .SLOT_W(SLOT_W)) u_lookup_op1 (
        .i_ent   (r_ent),
        .i_head  (w_head_slot),
        .i_raddr (rob.op1_raddr),
        .o_hit   (rob.op1_rob_hit),
        .o_rdy   (rob.op1_rob_rdy),
        .o_slot  (rob.op1_rob_slot)
    );

endmodule

// File: tb/tb_riscvio2i_rob_ctrl.sv
// Directed bench for the ROB control block with an in-order commit scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_riscvio2i_rob_ctrl;

    typedef struct {
        logic [3:0] slot;
        logic [4:0] waddr;
        logic       wen;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    riscvio2i_rob_ctrl_if #(.SLOT_W(4)) rob ();

    riscvio2i_rob_ctrl #(.ENTRIES(16), .SLOT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .rob   (rob)
    );

    always #5 clk = ~clk;

    int   n_pass  = 0;
    int   n_total = 0;
    int   n_fail  = 0;
    int   tb_tail = 0;
    bit   tb_valid [16];
    exp_t exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc_drive(input logic wen, input logic [4:0] waddr);
        rob.alloc_val   = 1'b1;
        rob.alloc_wen   = wen;
        rob.alloc_waddr = waddr;
        #1;
        chk("alloc_rdy", 32'(rob.alloc_rdy), 32'd1);
        chk("alloc_slot", 32'(rob.alloc_slot), 32'(tb_tail % 16));
    endtask

    task automatic alloc_finish(input logic wen, input logic [4:0] waddr);
        exp_t e;
        tick();
        rob.alloc_val = 1'b0;
        e.slot  = 4'(tb_tail % 16);
        e.waddr = waddr;
        e.wen   = wen && (waddr != 5'd0);
        exp_q.push_back(e);
        tb_valid[tb_tail % 16] = 1'b1;
        tb_tail++;
    endtask

    task automatic alloc(input logic wen, input logic [4:0] waddr);
        alloc_drive(wen, waddr);
        alloc_finish(wen, waddr);
    endtask

    task automatic fill(input int slot);
        chk("fill_to_valid_slot", 32'(tb_valid[slot]), 32'd1);
        rob.rob_fill_wen_Whl  = 1'b1;
        rob.rob_fill_slot_Whl = 4'(slot);
        tick();
        rob.rob_fill_wen_Whl  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        foreach (tb_valid[i]) tb_valid[i] = 1'b0;
        tb_tail = 0;
    endtask

    // Commit monitor: every retirement must match the oldest outstanding allocation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset && rob.commit_val === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("commit_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("commit_slot", 32'(rob.rob_commit_slot_Chl), 32'(e.slot));
                chk("commit_waddr", 32'(rob.rob_commit_waddr_Chl), 32'(e.waddr));
                chk("commit_wen", 32'(rob.rob_commit_wen_Chl), 32'(e.wen));
                tb_valid[e.slot] = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rob.alloc_val         = 1'b0;
        rob.alloc_wen         = 1'b0;
        rob.alloc_waddr       = 5'd0;
        rob.rob_fill_wen_Whl  = 1'b0;
        rob.rob_fill_slot_Whl = 4'd0;
        rob.op0_raddr         = 5'd0;
        rob.op1_raddr         = 5'd0;

        // reset state
        do_reset();
        rob.op0_raddr = 5'd3;
        rob.op1_raddr = 5'd4;
        #1;
        chk("rst_alloc_rdy", 32'(rob.alloc_rdy), 32'd1);
        chk("rst_empty", 32'(rob.rob_empty), 32'd1);
        chk("rst_full", 32'(rob.rob_full), 32'd0);
        chk("rst_commit_val", 32'(rob.commit_val), 32'd0);
        chk("rst_commit_wen", 32'(rob.rob_commit_wen_Chl), 32'd0);
        chk("rst_op0_hit", 32'(rob.op0_rob_hit), 32'd0);
        chk("rst_op0_rdy", 32'(rob.op0_rob_rdy), 32'd0);
        chk("rst_op1_hit", 32'(rob.op1_rob_hit), 32'd0);

        // fill the ROB with 16 unfilled allocations
        for (int i = 0; i < 16; i++) alloc(1'b1, 5'(i));
        #1;
        chk("full_flag", 32'(rob.rob_full), 32'd1);
        chk("full_alloc_rdy", 32'(rob.alloc_rdy), 32'd0);
        chk("full_commit_val", 32'(rob.commit_val), 32'd0);
        chk("full_empty", 32'(rob.rob_empty), 32'd0);

        // full + committable head: commit happens, allocation is held off one cycle
        fill(0);
        rob.alloc_val   = 1'b1;
        rob.alloc_wen   = 1'b1;
        rob.alloc_waddr = 5'd20;
        #1;
        chk("wrap_alloc_blocked", 32'(rob.alloc_rdy), 32'd0);
        chk("wrap_commit_val", 32'(rob.commit_val), 32'd1);
        chk("wrap_commit_slot0", 32'(rob.rob_commit_slot_Chl), 32'd0);
        tick();
        alloc(1'b1, 5'd20);
        #1;
        chk("wrap_full_again", 32'(rob.rob_full), 32'd1);
        for (int s = 1; s < 16; s++) fill(s);
        fill(0);
        #1;
        chk("wrap_last_commit_slot", 32'(rob.rob_commit_slot_Chl), 32'd0);
        chk("wrap_last_commit_waddr", 32'(rob.rob_commit_waddr_Chl), 32'd20);
        tick();
        #1;
        chk("wrap_drained", 32'(rob.rob_empty), 32'd1);

        // reset with entries in flight
        for (int i = 0; i < 5; i++) alloc(1'b1, 5'(10 + i));
        fill(3);
        #1;
        chk("inflight_no_commit", 32'(rob.commit_val), 32'd0);
        do_reset();
        rob.op0_raddr = 5'd10;
        #1;
        chk("mid_rst_empty", 32'(rob.rob_empty), 32'd1);
        chk("mid_rst_commit", 32'(rob.commit_val), 32'd0);
        chk("mid_rst_alloc_slot", 32'(rob.alloc_slot), 32'd0);
        chk("mid_rst_full", 32'(rob.rob_full), 32'd0);
        chk("mid_rst_op0_hit", 32'(rob.op0_rob_hit), 32'd0);

        // out-of-order fill, in-order commit
        alloc(1'b1, 5'd5);
        alloc(1'b1, 5'd6);
        alloc(1'b1, 5'd7);
        rob.op0_raddr = 5'd5;
        rob.op1_raddr = 5'd7;
        #1;
        chk("ooo_op0_hit", 32'(rob.op0_rob_hit), 32'd1);
        chk("ooo_op0_slot", 32'(rob.op0_rob_slot), 32'd0);
        chk("ooo_op0_rdy", 32'(rob.op0_rob_rdy), 32'd0);
        chk("ooo_op1_slot", 32'(rob.op1_rob_slot), 32'd2);
        fill(2);
        #1;
        chk("ooo_no_commit_after_fill2", 32'(rob.commit_val), 32'd0);
        chk("ooo_op1_rdy", 32'(rob.op1_rob_rdy), 32'd1);
        fill(0);
        #1;
        chk("ooo_commit0_val", 32'(rob.commit_val), 32'd1);
        chk("ooo_commit0_slot", 32'(rob.rob_commit_slot_Chl), 32'd0);
        fill(1);
        #1;
        chk("ooo_commit1_slot", 32'(rob.rob_commit_slot_Chl), 32'd1);
        chk("ooo_commit1_val", 32'(rob.commit_val), 32'd1);
        tick();
        #1;
        chk("ooo_commit2_slot", 32'(rob.rob_commit_slot_Chl), 32'd2);
        chk("ooo_commit2_waddr", 32'(rob.rob_commit_waddr_Chl), 32'd7);
        tick();
        #1;
        chk("ooo_empty", 32'(rob.rob_empty), 32'd1);
        chk("ooo_idle_commit", 32'(rob.commit_val), 32'd0);

        // two writers of x9: youngest wins, own allocation invisible
        alloc(1'b1, 5'd9);
        rob.op0_raddr = 5'd9;
        rob.op1_raddr = 5'd7;
        alloc_drive(1'b1, 5'd9);
        chk("self_alloc_invisible_slot", 32'(rob.op0_rob_slot), 32'd3);
        chk("self_alloc_invisible_hit", 32'(rob.op0_rob_hit), 32'd1);
        chk("retired_x7_no_hit", 32'(rob.op1_rob_hit), 32'd0);
        alloc_finish(1'b1, 5'd9);
        #1;
        chk("youngest_slot", 32'(rob.op0_rob_slot), 32'd4);
        fill(3);
        #1;
        chk("youngest_hit", 32'(rob.op0_rob_hit), 32'd1);
        chk("youngest_slot_after_fill3", 32'(rob.op0_rob_slot), 32'd4);
        chk("youngest_not_rdy", 32'(rob.op0_rob_rdy), 32'd0);
        chk("x9_commit3_slot", 32'(rob.rob_commit_slot_Chl), 32'd3);
        chk("fill_to_valid_slot", 32'(tb_valid[4]), 32'd1);
        rob.rob_fill_wen_Whl  = 1'b1;
        rob.rob_fill_slot_Whl = 4'd4;
        #1;
        chk("same_cycle_fill_invisible", 32'(rob.op0_rob_rdy), 32'd0);
        tick();
        rob.rob_fill_wen_Whl  = 1'b0;
        #1;
        chk("rdy_after_fill4", 32'(rob.op0_rob_rdy), 32'd1);
        chk("committing_still_hit", 32'(rob.op0_rob_hit), 32'd1);
        chk("committing_slot4", 32'(rob.rob_commit_slot_Chl), 32'd4);
        tick();
        #1;
        chk("x9_drained_hit", 32'(rob.op0_rob_hit), 32'd0);
        chk("x9_drained_empty", 32'(rob.rob_empty), 32'd1);

        // wen=0 and waddr=0 entries retire without a regfile write
        alloc(1'b0, 5'd12);
        alloc(1'b1, 5'd0);
        rob.op0_raddr = 5'd0;
        rob.op1_raddr = 5'd12;
        #1;
        chk("x0_no_hit", 32'(rob.op0_rob_hit), 32'd0);
        chk("nowen_no_hit", 32'(rob.op1_rob_hit), 32'd0);
        fill(5);
        #1;
        chk("nowen_commit_val", 32'(rob.commit_val), 32'd1);
        chk("nowen_commit_wen", 32'(rob.rob_commit_wen_Chl), 32'd0);
        fill(6);
        #1;
        chk("x0_commit_val", 32'(rob.commit_val), 32'd1);
        chk("x0_commit_wen", 32'(rob.rob_commit_wen_Chl), 32'd0);
        chk("x0_commit_slot", 32'(rob.rob_commit_slot_Chl), 32'd6);
        tick();
        #1;
        chk("head_advanced_empty", 32'(rob.rob_empty), 32'd1);
        chk("tail_slot_7", 32'(rob.alloc_slot), 32'd7);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
